// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only target.
// Pure definitions; no latency or flow control involved.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        DATA,
        ACK_DATA,
        IGNORE
    } state_t;

    localparam logic [6:0] WM8731_ADDR = 7'h1A;

    function automatic logic state_busy(input state_t s);
        return (s == ACK_ADDR) || (s == DATA) || (s == ACK_DATA);
    endfunction

endpackage

// File: rtl/i2c_sync.sv
// Two-flop synchronizer plus history flop with edge pulses, for one bus line.
// Latency: two clk to level, edges flagged on the cycle the synced level changes; no backpressure.
module i2c_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic hist;

    // Resets to 1 so an idle (pulled-up) bus produces no spurious edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            hist <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            hist <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~hist;
    assign fall  = ~sync & hist;

endmodule

// File: rtl/i2c_target.sv
// I2C write-only target: accepts a 2-byte write to DEV_ADDR and presents it on data with a valid pulse.
// Latency: about three clk from a bus edge to a reaction; the bus master cannot be stalled (no clock stretching).
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = WM8731_ADDR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            SCL,
    inout  wire             SDA,
    output logic [1:0][7:0] data,
    output logic            valid,
    output logic            busy
);

    logic scl_lvl;
    logic scl_rise;
    logic scl_fall;
    logic sda_lvl;
    logic sda_rise;
    logic sda_fall;

    i2c_sync u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .din   (SCL),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .din   (SDA),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    state_t          state;
    logic [2:0]      bit_cnt;
    logic            byte_cnt;
    logic            payload_full;
    logic [6:0]      shift;
    logic [1:0][7:0] shadow;
    logic            sda_oe;

    logic       start_det;
    logic       stop_det;
    logic [7:0] byte_in;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign byte_in   = {shift, sda_lvl};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            byte_cnt     <= 1'b0;
            payload_full <= 1'b0;
            shift        <= 7'd0;
            shadow       <= '0;
            sda_oe       <= 1'b0;
            data         <= '0;
            valid        <= 1'b0;
        end else begin
            valid <= 1'b0;
            // Bus conditions win over any SCL edge seen in the same cycle.
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
            end else if (start_det) begin
                state        <= ADDR;
                bit_cnt      <= 3'd0;
                byte_cnt     <= 1'b0;
                payload_full <= 1'b0;
                shadow       <= '0;
                sda_oe       <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= (byte_in[7:1] == DEV_ADDR && !byte_in[0]) ? ACK_ADDR : IGNORE;
                            end
                        end
                    end
                    ACK_ADDR, ACK_DATA: begin
                        // First fall starts the ACK drive, second fall (end of 9th clock) ends it.
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                state   <= DATA;
                                bit_cnt <= 3'd0;
                                if (state == ACK_DATA) begin
                                    byte_cnt <= ~byte_cnt;
                                    if (byte_cnt) begin
                                        data         <= shadow;
                                        valid        <= 1'b1;
                                        payload_full <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            shift   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (payload_full) begin
                                    state <= IGNORE;
                                end else begin
                                    shadow[~byte_cnt] <= byte_in;
                                    state             <= ACK_DATA;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = state_busy(state);
    assign SDA  = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit device address this target answers to.
REQ-002 SHALL have port clk  input  1  system clock (240 MHz); reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port SCL  input  1  I2C clock, pulled up externally, never driven by this block.
REQ-004 SHALL have port SDA  inout  1  I2C data, driven only to 0 or Z (open-drain).
REQ-005 SHALL have port data  output  [1:0][7:0]  received payload: data[1] is the first byte, data[0] the second.
REQ-006 SHALL have port valid  output  1  one-clk pulse when a complete 2-byte write has been received.
REQ-007 SHALL have port busy  output  1  high from an addressed START until the next STOP or abort.

Function
REQ-008 SHALL pass SCL and SDA each through a 2-FF synchronizer plus one history flop; all decisions use synchronized values and edges only.
REQ-009 SHALL detect START as a synchronized SDA falling edge while SCL is high, and STOP as a synchronized SDA rising edge while SCL is high.
REQ-010 SHALL sample SDA on each synchronized SCL rising edge, MSB first, and change its own SDA drive only on synchronized SCL falling edges.
REQ-011 SHALL implement states IDLE, ADDR, ACK_ADDR, DATA, ACK_DATA and IGNORE, with a 3-bit bit counter and a 1-bit byte counter.
REQ-012 IDLE -> ADDR on START; all other SCL/SDA activity in IDLE SHALL be ignored.
REQ-013 ADDR: after 8 bits, if addr[7:1]==DEV_ADDR and R/W==0 -> ACK_ADDR; otherwise -> IGNORE with SDA never driven.
REQ-014 ACK_ADDR / ACK_DATA: SHALL drive SDA low from the SCL falling edge after bit 8 to the SCL falling edge after the 9th clock, then release SDA.
REQ-015 DATA: after 8 bits, if byte counter <2 -> ACK_DATA and store the byte into a shadow register; a third or later byte SHALL NOT be acknowledged -> IGNORE.
REQ-016 On the falling edge that ends the second ACK_DATA, data SHALL load from the shadow registers and valid SHALL pulse exactly one clk in the same cycle.
REQ-017 data SHALL hold its value until the next valid; partial transactions SHALL leave data unchanged.
REQ-018 STOP in any state SHALL -> IDLE, release SDA and clear busy.
REQ-019 START in any non-IDLE state (repeated START) SHALL -> ADDR with counters and shadow cleared, discarding any partial payload.
REQ-020 busy SHALL be 1 in ACK_ADDR, ACK_DATA and DATA, and 0 in IDLE, ADDR and IGNORE.
REQ-021 If START/STOP coincides with an SCL edge in the same clk, START/STOP SHALL take priority.

Reset
REQ-022 On reset: state=IDLE, SDA=Z, valid=0, busy=0, data=16'h0000, counters=0, synchronizers=1 (bus idle).
REQ-023 Reset asserted mid-transaction SHALL release SDA on the first clk edge with reset high.

Structure
REQ-024 Package i2c_pkg SHALL hold the state enum and the constant WM8731_ADDR=7'h1A.
REQ-025 Sub-module i2c_sync (2-FF synchronizer, history flop, rise/fall outputs) SHALL be instantiated once for SCL and once for SDA.
REQ-026 Target size: 120-400 lines of RTL.

Verification
REQ-027 Write to 0x1A with bytes 0x1E, 0x00 at 400 kHz -> three ACKs, data=16'h1E00, a single valid pulse, busy low after STOP.
REQ-028 Write to 0x1B -> SDA never driven low by the target, no valid, data unchanged.
REQ-029 Address 0x1A with R/W=1 -> NACK, IGNORE until STOP, then IDLE.
REQ-030 Write to 0x1A with 0x12, 0x34, 0x56 -> bytes 1-2 ACKed, byte 3 NACKed, valid once, data=16'h1234.
REQ-031 Write to 0x1A with one byte 0xAA, then repeated START and write 0x55, 0x66 -> data=16'h5566, exactly one valid.
REQ-032 Assert reset during the SCL-low phase of ACK_ADDR -> SDA released within 1 clk, all outputs at reset values; the following write then completes normally.
